// File: rtl/alu_issue_sched.sv
// Two-requester ALU issue scheduler: round-robin enqueue into a 4-entry FIFO,
// head presented to the ALU and dequeued whenever the pipeline is not stalled.
module alu_issue_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req0_valid,
   input  logic [21:0] req0_instr,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [21:0] req1_instr,
   output logic        req1_ready,
   input  logic        stall,
   output logic [4:0]  alu_src1,
   output logic [4:0]  alu_src2,
   output logic [4:0]  alu_dest,
   output logic [6:0]  alu_opcode,
   output logic        alu_valid,
   output logic        issue_id,
   output logic [2:0]  q_count,
   output logic        idle,
   output logic [7:0]  issued0_cnt,
   output logic [7:0]  issued1_cnt
);

   logic [21:0] instr_q [4];
   logic [21:0] instr_d [4];
   logic [3:0]  tag_q, tag_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        rr_q, rr_d;
   logic [7:0]  cnt0_q, cnt0_d;
   logic [7:0]  cnt1_q, cnt1_d;
   logic        s1_occ_q, s1_occ_d;
   logic        s2_occ_q, s2_occ_d;

   logic        gnt_id;
   logic        enq;
   logic        issue;
   logic [21:0] gnt_instr;
   logic [21:0] head;

   // Grant goes to rr only on contention; a lone requester always wins.
   always_comb begin
      gnt_id    = (req0_valid && req1_valid) ? rr_q : req1_valid;
      gnt_instr = gnt_id ? req1_instr : req0_instr;
      enq       = (req0_valid || req1_valid) && rst && !flush && (cnt_q != 3'd4);
      req0_ready = enq && !gnt_id;
      req1_ready = enq && gnt_id;
   end

   always_comb begin
      head       = instr_q[rd_ptr_q];
      alu_opcode = head[21:15];
      alu_dest   = head[14:10];
      alu_src2   = head[9:5];
      alu_src1   = head[4:0];
      issue_id   = tag_q[rd_ptr_q];
      alu_valid  = rst && !flush && (cnt_q != 3'd0);
      issue      = alu_valid && !stall;
      q_count    = cnt_q;
      idle       = (cnt_q == 3'd0) && !s1_occ_q && !s2_occ_q;
      issued0_cnt = cnt0_q;
      issued1_cnt = cnt1_q;
   end

   always_comb begin
      instr_d  = instr_q;
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;

      if (enq) begin
         instr_d[wr_ptr_q] = gnt_instr;
         tag_d[wr_ptr_q]   = gnt_id;
         wr_ptr_d          = wr_ptr_q + 2'd1;
         rr_d              = !gnt_id;
      end

      if (issue) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
         if (tag_q[rd_ptr_q]) cnt1_d = cnt1_q + 8'd1;
         else                 cnt0_d = cnt0_q + 8'd1;
      end

      case ({enq, issue})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end

      // Stalled stage 1 keeps its occupant; the bubble shows up in stage 2.
      if (stall) begin
         s1_occ_d = s1_occ_q;
         s2_occ_d = 1'b0;
      end else begin
         s1_occ_d = issue;
         s2_occ_d = s1_occ_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rr_q     <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
         s1_occ_q <= 1'b0;
         s2_occ_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
         s1_occ_q <= s1_occ_d;
         s2_occ_q <= s2_occ_d;
      end
   end

   // Payload storage needs no reset: q_count alone decides what is valid.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      tag_q   <= tag_d;
   end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized and directed checks of alu_issue_sched against a queue-based model.
module tb_alu_issue_sched;

   logic        clk = 1'b0;
   logic        rst, flush, stall;
   logic        req0_valid, req1_valid;
   logic [21:0] req0_instr, req1_instr;
   logic        req0_ready, req1_ready;
   logic [4:0]  alu_src1, alu_src2, alu_dest;
   logic [6:0]  alu_opcode;
   logic        alu_valid, issue_id, idle;
   logic [2:0]  q_count;
   logic [7:0]  issued0_cnt, issued1_cnt;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;

   alu_issue_sched dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_ready(req1_ready),
      .stall(stall),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_dest(alu_dest), .alu_opcode(alu_opcode),
      .alu_valid(alu_valid), .issue_id(issue_id), .q_count(q_count), .idle(idle),
      .issued0_cnt(issued0_cnt), .issued1_cnt(issued1_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [21:0] instr; logic tag; } ent_t;
   ent_t        mq[$];
   logic        m_rr, m_s1, m_s2;
   logic [7:0]  m_c0, m_c1;
   logic        e_gid, e_enq, e_rdy0, e_rdy1, e_valid, e_issue, e_idle;
   logic [2:0]  e_cnt;
   ent_t        e_head;

   function automatic logic [21:0] head_bits();
      return {alu_opcode, alu_dest, alu_src2, alu_src1};
   endfunction

   task automatic model_comb();
      e_gid   = (req0_valid && req1_valid) ? m_rr : req1_valid;
      e_enq   = rst && !flush && (mq.size() < 4) && (req0_valid || req1_valid);
      e_rdy0  = e_enq && !e_gid;
      e_rdy1  = e_enq && e_gid;
      e_valid = rst && !flush && (mq.size() != 0);
      e_issue = e_valid && !stall;
      e_cnt   = 3'(mq.size());
      e_idle  = (mq.size() == 0) && !m_s1 && !m_s2;
      e_head  = (mq.size() != 0) ? mq[0] : '0;
   endtask

   task automatic model_clock();
      ent_t t;
      if (!rst) begin
         mq.delete();
         m_rr = 0; m_c0 = 0; m_c1 = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         if (flush) mq.delete();
         else begin
            if (e_issue) begin
               t = mq.pop_front();
               if (t.tag) m_c1++; else m_c0++;
            end
            if (e_enq) begin
               mq.push_back({e_gid ? req1_instr : req0_instr, e_gid});
               m_rr = !e_gid;
            end
         end
         if (!stall) begin m_s2 = m_s1; m_s1 = e_issue; end
         else m_s2 = 0;
      end
   endtask

   // Advance one clock; inputs change only at the falling edge.
   task automatic step();
      model_comb();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic quiet();
      flush = 0; stall = 0; req0_valid = 0; req1_valid = 0;
   endtask

   task automatic drain();
      quiet();
      repeat (6) step();
   endtask

   task automatic test_reset();
      rst = 0; quiet(); req0_instr = '0; req1_instr = '0;
      step(); step();
      req0_valid = 1; req1_valid = 1;
      #1;
      n_run++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_qcount got=%0d want=0", q_count); end
      n_run++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid got=%b want=0", alu_valid); end
      n_run++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b want=1", idle); end
      n_run++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
      n_run++; if ({issued0_cnt, issued1_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_counters got=%h want=0000", {issued0_cnt, issued1_cnt}); end
      rst = 1; quiet();
      step();
   endtask

   task automatic test_round_robin();
      int unsigned n_iss = 0;
      logic [7:0] c0 = issued0_cnt, c1 = issued1_cnt;
      for (int k = 0; k < 12; k++) begin
         req0_valid = (k < 8); req1_valid = (k < 8);
         req0_instr = 22'($urandom); req1_instr = 22'($urandom);
         #1;
         n_run++;
         if (req0_ready !== (k < 8 && k % 2 == 0)) begin
            n_fail++; $display("FAIL rr_grant0 k=%0d got=%b want=%b", k, req0_ready, (k < 8 && k % 2 == 0));
         end
         if (alu_valid) begin
            n_run++;
            if (issue_id !== 1'(n_iss % 2)) begin
               n_fail++; $display("FAIL rr_issue_id n=%0d got=%b want=%0d", n_iss, issue_id, n_iss % 2);
            end
            n_iss++;
         end
         step();
      end
      #1;
      n_run++; if (n_iss != 8) begin n_fail++; $display("FAIL rr_issue_total got=%0d want=8", n_iss); end
      n_run++; if (issued0_cnt !== c0 + 8'd4) begin n_fail++; $display("FAIL rr_cnt0 got=%0d want=%0d", issued0_cnt, c0 + 8'd4); end
      n_run++; if (issued1_cnt !== c1 + 8'd4) begin n_fail++; $display("FAIL rr_cnt1 got=%0d want=%0d", issued1_cnt, c1 + 8'd4); end
   endtask

   task automatic test_full_stall();
      logic [21:0] saved [5];
      drain();
      stall = 1; req0_valid = 1;
      for (int k = 0; k < 5; k++) begin
         saved[k] = {7'(k + 16), 15'($urandom)};
         req0_instr = saved[k];
         #1;
         n_run++;
         if (req0_ready !== (k < 4)) begin n_fail++; $display("FAIL full_ready k=%0d got=%b want=%b", k, req0_ready, (k < 4)); end
         if (k < 4) step();
      end
      req0_valid = 0;
      #1;
      n_run++; if (q_count !== 3'd4) begin n_fail++; $display("FAIL full_qcount got=%0d want=4", q_count); end
      stall = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_run++; if (head_bits() !== saved[k]) begin n_fail++; $display("FAIL full_order k=%0d got=%h want=%h", k, head_bits(), saved[k]); end
         n_run++; if (q_count !== 3'(4 - k)) begin n_fail++; $display("FAIL full_drain k=%0d got=%0d want=%0d", k, q_count, 4 - k); end
         step();
      end
      #1;
      n_run++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL full_empty got=%0d want=0", q_count); end
      req0_valid = 1; req0_instr = saved[4];
      #1;
      n_run++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL full_fifth got=%b want=1", req0_ready); end
      step();
      req0_valid = 0;
   endtask

   task automatic test_stall_hold();
      logic [21:0] ins;
      logic [7:0]  c0;
      drain();
      ins = {7'h05, 5'd7, 5'($urandom), 5'd3};
      stall = 1; req0_valid = 1; req0_instr = ins;
      step();
      req0_valid = 0;
      c0 = issued0_cnt;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_run++; if (head_bits() !== ins || alu_valid !== 1'b1) begin n_fail++; $display("FAIL hold_head k=%0d got=%h/%b want=%h/1", k, head_bits(), alu_valid, ins); end
         n_run++; if (q_count !== 3'd1 || issued0_cnt !== c0) begin n_fail++; $display("FAIL hold_nodeq k=%0d got=%0d/%0d want=1/%0d", k, q_count, issued0_cnt, c0); end
         step();
      end
      stall = 0;
      step();
      #1;
      n_run++; if (q_count !== 3'd0 || issued0_cnt !== c0 + 8'd1) begin n_fail++; $display("FAIL hold_issue got=%0d/%0d want=0/%0d", q_count, issued0_cnt, c0 + 8'd1); end
   endtask

   task automatic test_back_to_back();
      drain();
      stall = 1; req1_valid = 1;
      req1_instr = 22'($urandom); step();
      req1_instr = 22'($urandom); step();
      stall = 0;
      for (int k = 0; k < 8; k++) begin
         req1_instr = 22'($urandom);
         #1; model_comb();
         n_run++; if (q_count !== 3'd2) begin n_fail++; $display("FAIL b2b_qcount k=%0d got=%0d want=2", k, q_count); end
         n_run++; if (head_bits() !== e_head.instr || issue_id !== 1'b1) begin n_fail++; $display("FAIL b2b_order k=%0d got=%h want=%h", k, head_bits(), e_head.instr); end
         step();
      end
      req1_valid = 0;
   endtask

   task automatic test_flush();
      drain();
      stall = 1; req0_valid = 1;
      repeat (3) begin req0_instr = 22'($urandom); step(); end
      req0_valid = 0; req1_valid = 1; flush = 1;
      #1;
      n_run++; if (q_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got=%0d want=3", q_count); end
      n_run++; if (req1_ready !== 1'b0 || alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_block got=%b/%b want=0/0", req1_ready, alu_valid); end
      step();
      flush = 0; req1_valid = 0;
      #1;
      n_run++; if (q_count !== 3'd0 || alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post got=%0d/%b want=0/0", q_count, alu_valid); end
      stall = 0; req0_valid = 1; req0_instr = 22'($urandom);
      step();
      req0_valid = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         #1;
         n_run++; if (idle !== (k == 2)) begin n_fail++; $display("FAIL flush_idle k=%0d got=%b want=%b", k, idle, (k == 2)); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      drain();
      stall = 1; req0_valid = 1;
      repeat (3) begin req0_instr = 22'($urandom); step(); end
      req0_valid = 0; stall = 0; rst = 0;
      #1;
      n_run++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", alu_valid); end
      step();
      rst = 1;
      #1;
      n_run++; if (q_count !== 3'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_q got=%0d/%b want=0/1", q_count, idle); end
      n_run++; if ({issued0_cnt, issued1_cnt} !== 16'h0) begin n_fail++; $display("FAIL rstmid_cnt got=%h want=0000", {issued0_cnt, issued1_cnt}); end
      req0_valid = 1; req1_valid = 1;
      #1;
      n_run++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_rr got=%b want=10", {req0_ready, req1_ready}); end
      quiet();
   endtask

   task automatic test_random();
      for (int k = 0; k < 500; k++) begin
         rst        = ($urandom_range(0, 99) != 0);
         flush      = ($urandom_range(0, 29) == 0);
         stall      = ($urandom_range(0, 3) == 0);
         req0_valid = $urandom_range(0, 1) == 1;
         req1_valid = $urandom_range(0, 2) != 0;
         req0_instr = 22'($urandom);
         req1_instr = 22'($urandom);
         #1; model_comb();
         n_run++; if ({req0_ready, req1_ready} !== {e_rdy0, e_rdy1}) begin n_fail++; $display("FAIL rnd_ready k=%0d got=%b want=%b", k, {req0_ready, req1_ready}, {e_rdy0, e_rdy1}); end
         n_run++; if (alu_valid !== e_valid || q_count !== e_cnt || idle !== e_idle) begin
            n_fail++; $display("FAIL rnd_state k=%0d got=%b/%0d/%b want=%b/%0d/%b", k, alu_valid, q_count, idle, e_valid, e_cnt, e_idle);
         end
         n_run++; if (issued0_cnt !== m_c0 || issued1_cnt !== m_c1) begin n_fail++; $display("FAIL rnd_cnt k=%0d got=%0d/%0d want=%0d/%0d", k, issued0_cnt, issued1_cnt, m_c0, m_c1); end
         if (e_valid) begin
            n_run++; if (head_bits() !== e_head.instr || issue_id !== e_head.tag) begin
               n_fail++; $display("FAIL rnd_head k=%0d got=%h/%b want=%h/%b", k, head_bits(), issue_id, e_head.instr, e_head.tag);
            end
         end
         step();
      end
      rst = 1; quiet();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 0; quiet(); req0_instr = '0; req1_instr = '0;
      m_rr = 0; m_c0 = 0; m_c1 = 0; m_s1 = 0; m_s2 = 0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_full_stall();
      test_stall_hold();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
